// File: rtl/hyperbus_responder.sv
// hyperbus_responder: HyperBus-style memory responder with fixed initial latency, byte-masked writes and post-burst recovery.
// The burst pointer wraps modulo the memory depth. Higher address bits alias onto the same words.
module hyperbus_responder #(
    parameter int HBUS_ADDR_WIDTH = 32,
    parameter int HBUS_DATA_WIDTH = 16,
    parameter int MEM_AW          = 10,
    parameter int LATENCY         = 6,
    parameter int RECOVERY        = 2
) (
    input  logic                       hbus_clk,
    input  logic                       hbus_rst_n,
    input  logic [HBUS_ADDR_WIDTH-1:0] hbus_adr_i,
    input  logic [HBUS_DATA_WIDTH-1:0] hbus_dat_i,
    input  logic [1:0]                 hbus_mask_i,
    input  logic                       hbus_rrq,
    input  logic                       hbus_wrq,
    input  logic                       stall_i,
    output logic [HBUS_DATA_WIDTH-1:0] hbus_dat_o,
    output logic                       hbus_valid,
    output logic                       hbus_ready,
    output logic                       busy_o
);
    typedef enum logic [2:0] {IDLE, LAT, READ, WRITE, RECOV} state_t;
    state_t                     r_state, w_next;
    logic [MEM_AW-1:0]          r_ptr, w_ptr_inc;
    logic [3:0]                 r_lat_cnt, r_rec_cnt;
    logic                       r_dir_wr;
    logic [HBUS_DATA_WIDTH-1:0] r_mem [2**MEM_AW];
    logic                       w_act, w_accept, w_first;
    assign w_act      = r_dir_wr ? hbus_wrq : hbus_rrq;
    assign w_accept   = (r_state == IDLE) & (hbus_rrq | hbus_wrq);
    assign w_first    = (r_state == LAT) & (r_lat_cnt == 4'd0) & ~r_dir_wr & hbus_rrq;
    assign w_ptr_inc  = r_ptr + 1'b1;
    assign hbus_valid = (r_state == READ) & hbus_rrq & ~stall_i;
    assign hbus_ready = (r_state == WRITE) & hbus_wrq & ~stall_i;
    assign busy_o     = r_state != IDLE;
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_accept ? LAT : IDLE;
            LAT:     w_next = !w_act ? RECOV : (r_lat_cnt != 4'd0) ? LAT : (r_dir_wr ? WRITE : READ);
            READ:    w_next = hbus_rrq ? READ : RECOV;
            WRITE:   w_next = hbus_wrq ? WRITE : RECOV;
            RECOV:   w_next = (r_rec_cnt == 4'd0) ? IDLE : RECOV;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge hbus_clk or negedge hbus_rst_n) begin
        if (!hbus_rst_n) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_lat_cnt  <= '0;
            r_rec_cnt  <= '0;
            r_dir_wr   <= 1'b0;
            hbus_dat_o <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_ptr     <= MEM_AW'(hbus_adr_i);
                r_dir_wr  <= ~hbus_rrq;
                r_lat_cnt <= 4'(LATENCY - 1);
            end else if (hbus_valid | hbus_ready) begin
                r_ptr <= w_ptr_inc;
            end
            if (r_state == LAT && r_lat_cnt != 4'd0)
                r_lat_cnt <= r_lat_cnt - 4'd1;
            if (w_next == RECOV && r_state != RECOV)
                r_rec_cnt <= 4'(RECOVERY - 1);
            else if (r_state == RECOV && r_rec_cnt != 4'd0)
                r_rec_cnt <= r_rec_cnt - 4'd1;
            // prefetch keeps the output one word ahead so each beat needs no extra cycle
            if (w_first)
                hbus_dat_o <= r_mem[r_ptr];
            else if (hbus_valid)
                hbus_dat_o <= r_mem[w_ptr_inc];
        end
    end
    always_ff @(posedge hbus_clk) begin
        if (hbus_ready) begin
            if (!hbus_mask_i[0]) r_mem[r_ptr][7:0]  <= hbus_dat_i[7:0];
            if (!hbus_mask_i[1]) r_mem[r_ptr][15:8] <= hbus_dat_i[15:8];
        end
    end
endmodule

// File: tb/tb_hyperbus_responder.sv
// tb_hyperbus_responder: directed bench for hyperbus_responder with hand-computed expectations.
module tb_hyperbus_responder;
    logic        hbus_clk = 1'b0;
    logic        hbus_rst_n = 1'b0;
    logic [31:0] hbus_adr_i = '0;
    logic [15:0] hbus_dat_i = '0;
    logic [1:0]  hbus_mask_i = '0;
    logic        hbus_rrq = 1'b0, hbus_wrq = 1'b0, stall_i = 1'b0;
    logic [15:0] hbus_dat_o;
    logic        hbus_valid, hbus_ready, busy_o;
    int          n_chk = 0, n_pass = 0;
    logic [15:0] wd [8];
    logic [15:0] rd [8];
    int          first_lat, beats, tail, extra, stall_hits, last_cyc, st_lo = 0, st_hi = 0, n_valid;

    hyperbus_responder dut (
        .hbus_clk(hbus_clk), .hbus_rst_n(hbus_rst_n), .hbus_adr_i(hbus_adr_i),
        .hbus_dat_i(hbus_dat_i), .hbus_mask_i(hbus_mask_i), .hbus_rrq(hbus_rrq),
        .hbus_wrq(hbus_wrq), .stall_i(stall_i), .hbus_dat_o(hbus_dat_o),
        .hbus_valid(hbus_valid), .hbus_ready(hbus_ready), .busy_o(busy_o)
    );

    always #5 hbus_clk = ~hbus_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // counts busy cycles left after the request is withdrawn, plus any beats seen in them
    task automatic drain();
        tail = 0;
        extra = 0;
        while (tail < 50) begin
            @(negedge hbus_clk);
            if (!busy_o) break;
            tail++;
            if (hbus_valid | hbus_ready) extra++;
            @(posedge hbus_clk); #1;
        end
        @(posedge hbus_clk); #1;
    endtask

    // cyc 0 is the IDLE cycle whose closing edge accepts the request
    task automatic burst(input bit wr, input logic [31:0] adr, input int n, input logic [1:0] mask);
        int cyc;
        cyc = 0;
        beats = 0;
        first_lat = -1;
        last_cyc = -1;
        stall_hits = 0;
        hbus_adr_i = adr;
        hbus_mask_i = mask;
        hbus_dat_i = wd[0];
        stall_i = (st_lo <= 0) && (0 < st_hi);
        if (wr) hbus_wrq = 1'b1;
        else hbus_rrq = 1'b1;
        while (beats < n && cyc < 300) begin
            @(negedge hbus_clk);
            if (stall_i && (hbus_valid || hbus_ready)) stall_hits++;
            if (wr ? hbus_ready : hbus_valid) begin
                if (!wr) rd[beats] = hbus_dat_o;
                if (first_lat < 0) first_lat = cyc;
                last_cyc = cyc;
                beats++;
            end
            @(posedge hbus_clk); #1;
            cyc++;
            hbus_dat_i = wd[beats < 8 ? beats : 7];
            stall_i = (cyc >= st_lo) && (cyc < st_hi);
        end
        hbus_rrq = 1'b0;
        hbus_wrq = 1'b0;
        stall_i = 1'b0;
        drain();
    endtask

    initial begin
        #2;
        check("rst_busy", busy_o, 0);
        check("rst_valid", hbus_valid, 0);
        check("rst_ready", hbus_ready, 0);
        check("rst_dat", hbus_dat_o, 0);
        @(posedge hbus_clk); #3;
        hbus_rst_n = 1'b1;
        @(posedge hbus_clk); #1;

        wd = '{16'hA5A5, 16'h3C3C, 0, 0, 0, 0, 0, 0};
        burst(1, 32'h10, 2, 2'b00);
        check("pre_beats", beats, 2);
        check("pre_lat", first_lat - 1, 6);
        check("pre_extra", extra, 0);
        burst(0, 32'h10, 2, 2'b00);
        check("rd_beats", beats, 2);
        check("rd_lat", first_lat - 1, 6);
        check("rd_d0", rd[0], 16'hA5A5);
        check("rd_d1", rd[1], 16'h3C3C);
        check("rd_tail", tail, 3);
        check("rd_extra", extra, 0);

        wd = '{16'h1234, 0, 0, 0, 0, 0, 0, 0};
        burst(1, 32'h20, 1, 2'b00);
        check("w1_beats", beats, 1);
        check("w1_extra", extra, 0);
        wd = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        burst(1, 32'h20, 1, 2'b10);
        check("w2_beats", beats, 1);
        check("w2_extra", extra, 0);
        burst(0, 32'h20, 1, 2'b00);
        check("mask_rd", rd[0], 16'h12FF);

        wd = '{16'd1, 16'd2, 16'd3, 0, 0, 0, 0, 0};
        burst(1, 32'h3FF, 3, 2'b00);
        check("wrap_wbeats", beats, 3);
        burst(0, 32'h3FF, 3, 2'b00);
        check("wrap_3ff", rd[0], 16'd1);
        check("wrap_000", rd[1], 16'd2);
        check("wrap_001", rd[2], 16'd3);
        burst(0, 32'h0000_0401, 1, 2'b00);
        check("alias_401", rd[0], 16'd3);

        wd = '{16'hDEAD, 16'hDEAD, 16'hDEAD, 16'hDEAD, 16'hDEAD, 16'hDEAD, 16'hDEAD, 16'hDEAD};
        hbus_wrq = 1'b1;
        burst(0, 32'h20, 1, 2'b00);
        check("both_rd", rd[0], 16'h12FF);
        burst(0, 32'h20, 1, 2'b00);
        check("both_nowr", rd[0], 16'h12FF);

        wd = '{16'h0A01, 16'h0A02, 16'h0A03, 16'h0A04, 0, 0, 0, 0};
        burst(1, 32'h80, 4, 2'b00);
        st_lo = 8;
        st_hi = 11;
        burst(0, 32'h80, 4, 2'b00);
        check("stall_beats", beats, 4);
        check("stall_d0", rd[0], 16'h0A01);
        check("stall_d1", rd[1], 16'h0A02);
        check("stall_d2", rd[2], 16'h0A03);
        check("stall_d3", rd[3], 16'h0A04);
        check("stall_hits", stall_hits, 0);
        check("stall_last", last_cyc, 13);
        st_lo = 2;
        st_hi = 5;
        burst(0, 32'h80, 1, 2'b00);
        check("lat_stall", first_lat - 1, 6);
        st_lo = 0;
        st_hi = 0;

        n_valid = 0;
        hbus_adr_i = 32'h10;
        hbus_rrq = 1'b1;
        repeat (3) begin
            @(negedge hbus_clk);
            n_valid += int'(hbus_valid);
            @(posedge hbus_clk); #1;
        end
        hbus_rrq = 1'b0;
        drain();
        check("abort_valid", n_valid + extra, 0);
        check("abort_tail", tail, 3);
        burst(0, 32'h10, 1, 2'b00);
        check("abort_mem", rd[0], 16'hA5A5);

        wd = '{0, 0, 0, 0, 0, 0, 0, 0};
        burst(1, 32'h40, 4, 2'b00);
        hbus_adr_i = 32'h40;
        hbus_mask_i = 2'b00;
        hbus_dat_i = 16'h1111;
        hbus_wrq = 1'b1;
        n_valid = 0;
        while (n_valid < 40) begin
            @(negedge hbus_clk);
            if (hbus_ready) break;
            n_valid++;
            @(posedge hbus_clk); #1;
        end
        @(posedge hbus_clk); #1;
        hbus_dat_i = 16'h2222;
        @(negedge hbus_clk);
        check("rst_b2_ready", hbus_ready, 1);
        #1 hbus_rst_n = 1'b0;
        #1;
        check("mid_ready", hbus_ready, 0);
        check("mid_valid", hbus_valid, 0);
        check("mid_busy", busy_o, 0);
        check("mid_dat", hbus_dat_o, 0);
        #1 hbus_rst_n = 1'b1;
        hbus_wrq = 1'b0;
        @(posedge hbus_clk); #1;
        burst(0, 32'h40, 4, 2'b00);
        check("post_lat", first_lat - 1, 6);
        check("post_b1", rd[0], 16'h1111);
        check("post_b2", rd[1], 16'h0000);
        check("post_b3", rd[2], 16'h0000);
        check("post_b4", rd[3], 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
